// File: rtl/sp_ram_arb_pkg.sv
//------------------------------------------------------------------------------
// Module  : sp_ram_arb_pkg
// Brief   : Shared types and constants for the single-port RAM arbiter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sp_ram_arb_pkg;

  localparam int NUM_MASTERS    = 2;
  localparam int BUS_DATA_WIDTH = 32;
  localparam int BUS_BE_WIDTH   = BUS_DATA_WIDTH / 8;

  typedef struct packed {
    logic [31:0]               addr;
    logic                      we;
    logic [BUS_BE_WIDTH-1:0]   be;
    logic [BUS_DATA_WIDTH-1:0] wdata;
  } ram_req_t;

  typedef struct packed {
    logic                      rvalid;
    logic [BUS_DATA_WIDTH-1:0] rdata;
    logic                      err;
  } ram_rsp_t;

  // Full 32-bit compare so that high address bits can never alias into the RAM.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned size);
    return addr < size;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sp_ram_rr_arb.sv
//------------------------------------------------------------------------------
// Module  : sp_ram_rr_arb
// Brief   : Two-input round-robin arbiter, combinational one-hot grant.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sp_ram_rr_arb
  import sp_ram_arb_pkg::*;
(
  input  logic                   clk,
  input  logic                   rstn_i,
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic                   i_advance,
  output logic [NUM_MASTERS-1:0] o_gnt
);

  logic r_last_grant;

  // On conflict, the master that did not win last time is granted.
  always_comb begin
    o_gnt = i_req;
    if (&i_req) begin
      o_gnt = r_last_grant ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_last_grant <= 1'b1;
    end else if (i_advance) begin
      r_last_grant <= o_gnt[1];
    end
  end

endmodule

`default_nettype wire

// File: rtl/sp_ram_arb.sv
//------------------------------------------------------------------------------
// Module  : sp_ram_arb
// Brief   : Two-master round-robin arbiter in front of a single-port RAM.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sp_ram_arb
  import sp_ram_arb_pkg::*;
#(
  parameter int unsigned RAM_SIZE   = 262144,
  parameter int          ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int          DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rstn_i,
  input  logic                    m0_req_i,
  output logic                    m0_gnt_o,
  input  logic [31:0]             m0_addr_i,
  input  logic                    m0_we_i,
  input  logic [DATA_WIDTH/8-1:0] m0_be_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  output logic                    m0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,
  output logic                    m0_err_o,
  input  logic                    m1_req_i,
  output logic                    m1_gnt_o,
  input  logic [31:0]             m1_addr_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m1_be_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  output logic                    m1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,
  output logic                    m1_err_o,
  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

  ram_req_t               w_req [NUM_MASTERS];
  ram_rsp_t               w_rsp [NUM_MASTERS];
  ram_req_t               w_sel;
  logic [NUM_MASTERS-1:0] w_req_vld;
  logic [NUM_MASTERS-1:0] w_gnt;
  logic                   w_any_gnt;
  logic                   w_sel_in_range;
  logic                   w_ram_go;

  logic [NUM_MASTERS-1:0] r_rsp_valid;
  logic                   r_rsp_is_read;
  logic                   r_rsp_err;

  assign w_req[0]  = '{addr: m0_addr_i, we: m0_we_i, be: m0_be_i, wdata: m0_wdata_i};
  assign w_req[1]  = '{addr: m1_addr_i, we: m1_we_i, be: m1_be_i, wdata: m1_wdata_i};
  assign w_req_vld = {m1_req_i, m0_req_i};

  sp_ram_rr_arb u_arb (
    .clk       (clk),
    .rstn_i    (rstn_i),
    .i_req     (w_req_vld),
    .i_advance (w_any_gnt),
    .o_gnt     (w_gnt)
  );

  assign m0_gnt_o       = w_gnt[0];
  assign m1_gnt_o       = w_gnt[1];
  assign w_any_gnt      = |w_gnt;
  assign w_sel          = w_req[w_gnt[1]];
  assign w_sel_in_range = addr_in_range(w_sel.addr, RAM_SIZE);
  assign w_ram_go       = w_any_gnt & w_sel_in_range;

  // Out-of-range requests are still granted but never reach the RAM.
  assign ram_en_o    = w_ram_go;
  assign ram_addr_o  = w_sel.addr[ADDR_WIDTH-1:0];
  assign ram_wdata_o = w_sel.wdata;
  assign ram_we_o    = w_ram_go & w_sel.we;
  assign ram_be_o    = w_ram_go ? w_sel.be : '0;

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_rsp_valid   <= '0;
      r_rsp_is_read <= 1'b0;
      r_rsp_err     <= 1'b0;
    end else begin
      r_rsp_valid <= w_gnt;
      if (w_any_gnt) begin
        r_rsp_is_read <= ~w_sel.we;
        r_rsp_err     <= ~w_sel_in_range;
      end
    end
  end

  for (genvar n = 0; n < NUM_MASTERS; n++) begin : g_rsp
    assign w_rsp[n] = '{
      rvalid: r_rsp_valid[n],
      rdata:  (r_rsp_valid[n] & r_rsp_is_read & ~r_rsp_err) ? ram_rdata_i : '0,
      err:    r_rsp_valid[n] & r_rsp_err
    };
  end

  assign m0_rvalid_o = w_rsp[0].rvalid;
  assign m0_rdata_o  = w_rsp[0].rdata;
  assign m0_err_o    = w_rsp[0].err;
  assign m1_rvalid_o = w_rsp[1].rvalid;
  assign m1_rdata_o  = w_rsp[1].rdata;
  assign m1_err_o    = w_rsp[1].err;

endmodule

`default_nettype wire

// File: tb/tb_sp_ram_arb.sv
//------------------------------------------------------------------------------
// Module  : tb_sp_ram_arb
// Brief   : Self-checking bench for sp_ram_arb with a behavioural RAM and model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sp_ram_arb;

  localparam int unsigned RAM_SIZE = 4096;
  localparam int          AW       = 12;
  localparam int          DW       = 32;

  logic          clk = 1'b0;
  logic          rstn_i;
  logic          m0_req_i, m1_req_i, m0_we_i, m1_we_i;
  logic [31:0]   m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i;
  logic [3:0]    m0_be_i, m1_be_i;
  logic          m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o;
  logic [31:0]   m0_rdata_o, m1_rdata_o;
  logic          ram_en_o, ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [31:0]   ram_wdata_o;
  logic [3:0]    ram_be_o;
  logic [31:0]   ram_rdata = 32'hA5A5_A5A5;

  always #5 clk = ~clk;

  sp_ram_arb #(.RAM_SIZE(RAM_SIZE), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rstn_i(rstn_i),
    .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i),
    .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i), .m0_rvalid_o(m0_rvalid_o),
    .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
    .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i),
    .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i), .m1_rvalid_o(m1_rvalid_o),
    .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
    .ram_en_o(ram_en_o), .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
    .ram_we_o(ram_we_o), .ram_be_o(ram_be_o), .ram_rdata_i(ram_rdata)
  );

  // Behavioural single-port RAM: byte-enabled write, one-cycle read latency.
  logic [31:0] ram_mem [0:RAM_SIZE/4-1] = '{default: 32'h0};
  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (ram_be_o[b]) ram_mem[ram_addr_o[AW-1:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
      end
      ram_rdata <= ram_mem[ram_addr_o[AW-1:2]];
    end
  end

  // Reference model state
  logic [31:0] ref_mem [0:RAM_SIZE/4-1] = '{default: 32'h0};
  int          exp_last;
  int          last_winner;
  logic        p_req   [2];
  logic [31:0] p_addr  [2];
  logic        p_we    [2];
  logic [3:0]  p_be    [2];
  logic [31:0] p_wdata [2];
  logic [31:0] obs_rdata [2];
  int          rv1_count;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic set_req(input int n, input logic [31:0] addr, input logic we,
                         input logic [3:0] be, input logic [31:0] wdata);
    p_req[n] = 1'b1; p_addr[n] = addr; p_we[n] = we; p_be[n] = be; p_wdata[n] = wdata;
  endtask

  task automatic drive();
    m0_req_i = p_req[0]; m0_addr_i = p_addr[0]; m0_we_i = p_we[0];
    m0_be_i  = p_be[0];  m0_wdata_i = p_wdata[0];
    m1_req_i = p_req[1]; m1_addr_i = p_addr[1]; m1_we_i = p_we[1];
    m1_be_i  = p_be[1];  m1_wdata_i = p_wdata[1];
  endtask

  // One cycle: drive, check grant and RAM side, then check the response next cycle.
  task automatic step();
    logic [1:0]  g;
    int          w;
    logic        inr;
    logic [31:0] nxt_rd;
    drive();
    #1;
    w = -1; g = 2'b00; inr = 1'b1; nxt_rd = 32'h0;
    if (p_req[0] && p_req[1]) w = (exp_last == 1) ? 0 : 1;
    else if (p_req[0])        w = 0;
    else if (p_req[1])        w = 1;
    if (w >= 0) g[w] = 1'b1;
    chk("gnt0", {31'h0, m0_gnt_o}, {31'h0, g[0]});
    chk("gnt1", {31'h0, m1_gnt_o}, {31'h0, g[1]});
    if (w >= 0) begin
      inr = (p_addr[w] < RAM_SIZE);
      chk("ram_en", {31'h0, ram_en_o}, {31'h0, inr});
      if (inr) begin
        chk("ram_addr", {20'h0, ram_addr_o}, p_addr[w] % RAM_SIZE);
        chk("ram_we", {31'h0, ram_we_o}, {31'h0, p_we[w]});
        chk("ram_be", {28'h0, ram_be_o}, {28'h0, p_be[w]});
        if (p_we[w]) begin
          chk("ram_wdata", ram_wdata_o, p_wdata[w]);
          for (int b = 0; b < 4; b++)
            if (p_be[w][b]) ref_mem[p_addr[w] / 4][8*b +: 8] = p_wdata[w][8*b +: 8];
        end else begin
          nxt_rd = ref_mem[p_addr[w] / 4];
        end
      end else begin
        chk("ram_we_oor", {31'h0, ram_we_o}, 32'h0);
      end
      exp_last    = w;
      last_winner = w;
      p_req[w]    = 1'b0;
    end else begin
      chk("ram_en_idle", {31'h0, ram_en_o}, 32'h0);
      chk("ram_we_idle", {31'h0, ram_we_o}, 32'h0);
      chk("ram_be_idle", {28'h0, ram_be_o}, 32'h0);
    end
    @(posedge clk);
    #1;
    chk("rvalid0", {31'h0, m0_rvalid_o}, {31'h0, g[0]});
    chk("rvalid1", {31'h0, m1_rvalid_o}, {31'h0, g[1]});
    chk("err0", {31'h0, m0_err_o}, {31'h0, (w == 0) && !inr});
    chk("err1", {31'h0, m1_err_o}, {31'h0, (w == 1) && !inr});
    chk("rdata0", m0_rdata_o, (w == 0) ? nxt_rd : 32'h0);
    chk("rdata1", m1_rdata_o, (w == 1) ? nxt_rd : 32'h0);
    obs_rdata[0] = m0_rdata_o;
    obs_rdata[1] = m1_rdata_o;
    if (m1_rvalid_o) rv1_count++;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_gnt"},    {30'h0, m1_gnt_o, m0_gnt_o}, 32'h0);
    chk({tag, "_rvalid"}, {30'h0, m1_rvalid_o, m0_rvalid_o}, 32'h0);
    chk({tag, "_err"},    {30'h0, m1_err_o, m0_err_o}, 32'h0);
    chk({tag, "_rdata"},  m0_rdata_o | m1_rdata_o, 32'h0);
    chk({tag, "_ram"},    {27'h0, ram_en_o, ram_we_o, ram_be_o}, 32'h0);
  endtask

  initial begin
    rstn_i = 1'b0;
    for (int n = 0; n < 2; n++) begin
      p_req[n] = 1'b0; p_addr[n] = 32'h0; p_we[n] = 1'b0; p_be[n] = 4'h0; p_wdata[n] = 32'h0;
    end
    drive();
    exp_last = 1; last_winner = -1; rv1_count = 0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rstn_i = 1'b1;

    // Conflict right after reset: alternating grants starting with m0.
    for (int i = 0; i < 4; i++) begin
      for (int n = 0; n < 2; n++)
        if (!p_req[n]) set_req(n, $urandom_range(0, 63) * 4, 1'b0, 4'hF, 32'h0);
      step();
      chk("conflict_order", last_winner, i % 2);
    end
    while (p_req[0] || p_req[1]) step();

    // Preload and single read.
    set_req(0, 32'h100, 1'b1, 4'hF, 32'hDEADBEEF); step();
    set_req(1, 32'h100, 1'b0, 4'hF, 32'h0);        step();
    chk("single_read", obs_rdata[1], 32'hDEADBEEF);

    // Partial byte write then read.
    set_req(0, 32'h40, 1'b1, 4'b0010, 32'h11223344); step();
    chk("byte_wr_rdata", obs_rdata[0], 32'h0);
    set_req(0, 32'h40, 1'b0, 4'hF, 32'h0);           step();
    chk("byte_rd", obs_rdata[0], 32'h00003300);

    // Range boundaries.
    set_req(1, RAM_SIZE, 1'b0, 4'hF, 32'h0);      step();
    set_req(1, 32'hFFFF_FFFC, 1'b0, 4'hF, 32'h0); step();
    set_req(1, 32'hFFFF_FFFC, 1'b1, 4'hF, 32'hCAFEF00D); step();
    set_req(1, RAM_SIZE - 4, 1'b0, 4'hF, 32'h0);  step();

    // Throughput: 16 writes then 16 reads, no bubbles.
    rv1_count = 0;
    for (int i = 0; i < 32; i++) begin
      set_req(1, 32'h200 + (i % 16) * 4, (i < 16), 4'hF, $urandom);
      step();
    end
    chk("throughput_rvalids", rv1_count, 32);

    // Reset in the cycle after a grant: the pending response must vanish.
    set_req(1, 32'h100, 1'b0, 4'hF, 32'h0);
    drive();
    #1;
    chk("pre_rst_gnt1", {31'h0, m1_gnt_o}, 32'h1);
    p_req[1] = 1'b0;
    @(posedge clk);
    rstn_i = 1'b0;
    drive();
    #1;
    check_idle_outputs("rst_mid");
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("rst_hold");
    rstn_i = 1'b1;
    exp_last = 1;
    set_req(0, 32'h8, 1'b0, 4'hF, 32'h0);
    set_req(1, 32'hC, 1'b0, 4'hF, 32'h0);
    step();
    chk("post_rst_first", last_winner, 0);
    step();
    chk("post_rst_second", last_winner, 1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      for (int n = 0; n < 2; n++) begin
        if (!p_req[n] && ($urandom_range(0, 9) < 7)) begin
          logic [31:0] a;
          case ($urandom_range(0, 11))
            0:       a = RAM_SIZE;
            1:       a = 32'hFFFF_FFFC;
            2:       a = RAM_SIZE - 4;
            3:       a = $urandom & 32'hFFFF_FFFC;
            default: a = $urandom_range(0, 15) * 4;
          endcase
          set_req(n, a, $urandom_range(0, 1) == 1, 4'($urandom), $urandom);
        end
      end
      step();
    end
    p_req[0] = 1'b0; p_req[1] = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
